rtc_disp_ctrl: RTL and testbench
================================

Name: rtc_disp_ctrl

Overview:
Parametrised time-of-day controller and display scanner, the successor to the fixed 3-digit clock top. It holds a BCD hh:mm:ss counter driven by an internal 1 Hz prescaler. It adds a set-mode FSM with per-field increment and hold-to-repeat, plus runtime 12/24 h display formatting. It scans 4 (HH MM) or 6 (HH MM SS) multiplexed digits and outputs BCD, so the existing 7-segment decoder sits downstream.

Parameters:
CLK_HZ, 50_000_000, i_clk frequency; prescaler wraps at CLK_HZ-1.
SCAN_TICKS, 200_000, i_clk cycles each digit stays enabled.
NUM_DIGITS, 4, displayed digits; legal values 4 or 6 only. Any other value is an elaboration error.
REPEAT_DELAY, 25_000_000, cycles i_inc must be held before auto-repeat starts.
REPEAT_PERIOD, 5_000_000, cycles between auto-repeat increments.

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous reset, active-high
i_mode  in  1  debounced single-cycle pulse; advances set FSM
i_inc  in  1  debounced level; increments selected field
i_fmt_12h  in  1  1 = 12 h display, 0 = 24 h; sampled every cycle
o_digit_en  out  NUM_DIGITS  one-hot digit enable, bit 0 = leftmost digit
o_bcd  out  4  BCD value of the enabled digit; 4'hF = blank
o_dp  out  1  decimal point for the enabled digit
o_pm  out  1  1 in 12 h mode when hour >= 12; 0 in 24 h mode
o_setting  out  2  0 = RUN, 1 = SET_HOUR, 2 = SET_MIN, 3 = SET_SEC
o_hh, o_mm, o_ss  out  8 each  packed BCD time (tens in [7:4]); always 24 h

Behaviour:
- Interface: one clock; reset is synchronous and active-high. All state and outputs update on posedge i_clk.
- Reset values: time 00:00:00, state RUN, prescaler 0, scan index 0, o_digit_en = 1, o_bcd = 0, o_dp = 0, o_pm = 0, o_setting = 0, repeat counter idle.
- Prescaler: counts only in RUN. 1-cycle tick when the count equals CLK_HZ-1, then wraps to 0. Forced to 0 on every transition SET_* -> RUN.
- Time counter on tick: ss +1. 59 -> 00 carries into mm. mm 59 -> 00 carries into hh. hh 23 -> 00. All carries resolve in the same cycle, so 23:59:59 -> 00:00:00 in one tick.
- FSM, transitions on i_mode pulse:
  - RUN -> SET_HOUR -> SET_MIN.
  - SET_MIN -> SET_SEC if NUM_DIGITS = 6, else SET_MIN -> RUN.
  - SET_SEC -> RUN.
  - No ticks occur in any SET_* state.
- Increment, SET_* states only:
  - One increment on the cycle after the i_inc rising edge.
  - While i_inc stays high: a further increment after REPEAT_DELAY cycles, then one every REPEAT_PERIOD cycles.
  - Release clears the repeat counter.
  - Selected field wraps (hh 23 -> 00, mm/ss 59 -> 00) with no carry into other fields.
  - Entering SET_SEC does not clear ss.
- Simultaneous events: i_mode and an increment in the same cycle -> the mode change wins and the increment is dropped; the repeat counter is cleared. i_inc held in RUN has no effect; held across a transition into SET_* it counts as a new rising edge.
- 12 h format (display only; o_hh is unaffected):
  - hour 0 shows 12, o_pm = 0.
  - hours 1-11 show 1-11, o_pm = 0.
  - hour 12 shows 12, o_pm = 1.
  - hours 13-23 show hour-12, o_pm = 1.
  - The hour tens digit is blanked (4'hF) when it is 0.
  - In 24 h mode no digit is blanked.
- Scan:
  - Scan counter counts 0..SCAN_TICKS-1, then the index advances and wraps at NUM_DIGITS.
  - o_digit_en, o_bcd and o_dp are registered together and change in the same cycle.
  - Digit order: hour tens, hour ones, min tens, min ones, then sec tens, sec ones when NUM_DIGITS = 6.
- o_dp: asserted on the hour-ones digit in RUN while prescaler < CLK_HZ/2, giving a 1 Hz colon blink. Asserted steadily on the ones digit of the selected field in SET_* states.

Optional Feature:
RTC_BLINK_EN
- Defined: in SET_* states both digits of the selected field output 4'hF while blink phase = 0. The blink phase toggles every CLK_HZ/4 cycles from a free-running counter that is reset on i_rst.
- Undefined: no blanking; the selected field is indicated only by o_dp and o_setting.

Test Plan:
1. Parameters CLK_HZ = 10, SCAN_TICKS = 2, NUM_DIGITS = 4. Assert i_rst 3 cycles -> o_hh/o_mm/o_ss = 00, o_digit_en = 4'b0001, o_setting = 0. After 2 cycles o_digit_en = 4'b0010.
2. Set 23:59:59 via SET_* increments, return to RUN, wait 10 cycles -> o_hh/o_mm/o_ss = 00 on the tick cycle. Prescaler = 0 on the first RUN cycle.
3. i_fmt_12h = 1:
   - hour 00 -> digits {1,2}, o_pm = 0.
   - hour 13 -> digits {F,1}, o_pm = 1.
   - hour 12 -> {1,2}, o_pm = 1.
4. SET_MIN with mm = 58, REPEAT_DELAY = 20, REPEAT_PERIOD = 5. Hold i_inc 36 cycles -> mm sequence 59, 00, 01, 02, 03; o_hh unchanged.
5. NUM_DIGITS = 4, 3 i_mode pulses -> o_setting 1, 2, 0. NUM_DIGITS = 6 -> 1, 2, 3; a 4th pulse -> 0. i_mode together with an i_inc edge -> no increment.
6. Reset asserted mid SET_HOUR with i_inc held -> next cycle o_setting = 0, time 00:00:00; no increment after reset release until a new i_inc rising edge.

Source files
------------

// File: rtl/rtc_disp_ctrl.sv
// rtc_disp_ctrl: BCD hh:mm:ss clock with set FSM, 12/24 h display and digit scanner; RTC_BLINK_EN blanks the field being set.
module rtc_disp_ctrl #(
  parameter int CLK_HZ        = 50_000_000,
  parameter int SCAN_TICKS    = 200_000,
  parameter int NUM_DIGITS    = 4,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_mode,
  input  logic                  i_inc,
  input  logic                  i_fmt_12h,
  output logic [NUM_DIGITS-1:0] o_digit_en,
  output logic [3:0]            o_bcd,
  output logic                  o_dp,
  output logic                  o_pm,
  output logic [1:0]            o_setting,
  output logic [7:0]            o_hh,
  output logic [7:0]            o_mm,
  output logic [7:0]            o_ss
);
  localparam int PW = $clog2(CLK_HZ + 1);
  localparam int SW = $clog2(SCAN_TICKS + 1);
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);

  if (NUM_DIGITS != 4 && NUM_DIGITS != 6) begin : g_bad_digits
    $error("rtc_disp_ctrl: NUM_DIGITS must be 4 or 6");
  end

  typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN, SET_SEC} state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [7:0]              hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic                    inc_q, inc_d;
  logic [RW-1:0]           rep_q, rep_d;
  logic                    rep_ph_q, rep_ph_d;
  logic [SW-1:0]           scan_q, scan_d;
  logic [2:0]              idx_q, idx_d;
  logic [NUM_DIGITS-1:0]   en_q, en_d;
  logic [3:0]              bcd_q, bcd_d;
  logic                    dp_q, dp_d, pm_q, pm_d;
  logic                    set, tick, rise, rep_fire, bump, scan_wrap;
  logic [4:0]              hbin, h12, hdisp;
  logic [3:0]              htens, hones;
  logic [3:0]              dig [8];

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    return v == lim ? 8'h00 : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction

`ifdef RTC_BLINK_EN
  localparam int BW = $clog2(CLK_HZ / 4 + 1);
  logic [BW-1:0] blk_cnt_q;
  logic          blink_q;
  always_ff @(posedge i_clk)
    if (i_rst) begin
      blk_cnt_q <= '0;
      blink_q   <= 1'b0;
    end else if (blk_cnt_q == BW'(CLK_HZ / 4 - 1)) begin
      blk_cnt_q <= '0;
      blink_q   <= ~blink_q;
    end else begin
      blk_cnt_q <= blk_cnt_q + 1'b1;
    end
`endif

  always_comb begin
    set       = state_q != RUN;
    state_d   = !i_mode ? state_q :
                state_q == RUN ? SET_HOUR :
                state_q == SET_HOUR ? SET_MIN :
                (state_q == SET_MIN && NUM_DIGITS == 6) ? SET_SEC : RUN;
    tick      = !set && presc_q == PW'(CLK_HZ - 1);
    presc_d   = (set && state_d == RUN) ? '0 : set ? presc_q : tick ? '0 : presc_q + 1'b1;
    // edge history only survives inside a SET_* state, so entering one with i_inc held acts as a fresh press
    rise      = i_inc && !inc_q;
    inc_d     = set && !i_mode && i_inc;
    rep_fire  = rep_q == (rep_ph_q ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY));
    bump      = inc_d && (rise || rep_fire);
    rep_d     = !inc_d ? '0 : (rise || rep_fire) ? RW'(1) : rep_q + 1'b1;
    rep_ph_d  = inc_d && !rise && (rep_fire || rep_ph_q);
    ss_d      = (tick || (bump && state_q == SET_SEC)) ? bcd_inc(ss_q, 8'h59) : ss_q;
    mm_d      = ((tick && ss_q == 8'h59) || (bump && state_q == SET_MIN)) ? bcd_inc(mm_q, 8'h59) : mm_q;
    hh_d      = ((tick && ss_q == 8'h59 && mm_q == 8'h59) || (bump && state_q == SET_HOUR)) ?
                bcd_inc(hh_q, 8'h23) : hh_q;
    hbin      = 5'(hh_q[7:4]) * 5'd10 + 5'(hh_q[3:0]);
    h12       = hbin == 5'd0 ? 5'd12 : hbin > 5'd12 ? hbin - 5'd12 : hbin;
    hdisp     = i_fmt_12h ? h12 : hbin;
    htens     = 4'(hdisp / 5'd10);
    hones     = 4'(hdisp % 5'd10);
    pm_d      = i_fmt_12h && hbin >= 5'd12;
    dig       = '{default: 4'hF};
    dig[0]    = (i_fmt_12h && htens == 4'd0) ? 4'hF : htens;
    dig[1]    = hones;
    dig[2]    = mm_q[7:4];
    dig[3]    = mm_q[3:0];
    dig[4]    = ss_q[7:4];
    dig[5]    = ss_q[3:0];
`ifdef RTC_BLINK_EN
    for (int k = 0; k < 6; k++)
      if (set && !blink_q && k / 2 == int'(state_q) - 1) dig[k] = 4'hF;
`endif
    scan_wrap = scan_q == SW'(SCAN_TICKS - 1);
    scan_d    = scan_wrap ? '0 : scan_q + 1'b1;
    idx_d     = !scan_wrap ? idx_q : idx_q == 3'(NUM_DIGITS - 1) ? 3'd0 : idx_q + 3'd1;
    en_d      = NUM_DIGITS'(1) << idx_d;
    bcd_d     = dig[idx_d];
    dp_d      = set ? idx_d == {state_q, 1'b1} - 3'd2 : idx_d == 3'd1 && presc_q < PW'(CLK_HZ / 2);
  end

  always_ff @(posedge i_clk)
    if (i_rst) begin
      state_q  <= RUN;
      presc_q  <= '0;
      hh_q     <= '0;
      mm_q     <= '0;
      ss_q     <= '0;
      inc_q    <= 1'b0;
      rep_q    <= '0;
      rep_ph_q <= 1'b0;
      scan_q   <= '0;
      idx_q    <= '0;
      en_q     <= NUM_DIGITS'(1);
      bcd_q    <= '0;
      dp_q     <= 1'b0;
      pm_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      hh_q     <= hh_d;
      mm_q     <= mm_d;
      ss_q     <= ss_d;
      inc_q    <= inc_d;
      rep_q    <= rep_d;
      rep_ph_q <= rep_ph_d;
      scan_q   <= scan_d;
      idx_q    <= idx_d;
      en_q     <= en_d;
      bcd_q    <= bcd_d;
      dp_q     <= dp_d;
      pm_q     <= pm_d;
    end

  assign o_digit_en = en_q;
  assign o_bcd      = bcd_q;
  assign o_dp       = dp_q;
  assign o_pm       = pm_q;
  assign o_setting  = state_q;
  assign o_hh       = hh_q;
  assign o_mm       = mm_q;
  assign o_ss       = ss_q;
endmodule

// File: tb/tb_rtc_disp_ctrl.sv
// tb_rtc_disp_ctrl: directed vectors for rtc_disp_ctrl with 4- and 6-digit instances.
module tb_rtc_disp_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fmt = 1'b0;
  logic mode4 = 1'b0, inc4 = 1'b0, mode6 = 1'b0, inc6 = 1'b0;
  logic [3:0] en4, bcd4;
  logic [5:0] en6;
  logic [3:0] bcd6;
  logic dp4, pm4, dp6, pm6;
  logic [1:0] set4, set6;
  logic [7:0] hh4, mm4, ss4, hh6, mm6, ss6;
  int applied = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rtc_disp_ctrl #(.CLK_HZ(10), .SCAN_TICKS(2), .NUM_DIGITS(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)) u4 (
    .i_clk(clk), .i_rst(rst), .i_mode(mode4), .i_inc(inc4), .i_fmt_12h(fmt),
    .o_digit_en(en4), .o_bcd(bcd4), .o_dp(dp4), .o_pm(pm4), .o_setting(set4),
    .o_hh(hh4), .o_mm(mm4), .o_ss(ss4));

  rtc_disp_ctrl #(.CLK_HZ(10), .SCAN_TICKS(2), .NUM_DIGITS(6), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)) u6 (
    .i_clk(clk), .i_rst(rst), .i_mode(mode6), .i_inc(inc6), .i_fmt_12h(fmt),
    .o_digit_en(en6), .o_bcd(bcd6), .o_dp(dp6), .o_pm(pm6), .o_setting(set6),
    .o_hh(hh6), .o_mm(mm6), .o_ss(ss6));

  typedef struct {
    logic [7:0] hh;
    logic       fmt;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       pm;
  } fmt_vec_t;
  fmt_vec_t tv [10];

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    applied++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic pulse_mode(input bit six);
    if (six) mode6 = 1'b1; else mode4 = 1'b1;
    step(1);
    mode4 = 1'b0;
    mode6 = 1'b0;
  endtask

  task automatic bump(input bit six, input int n);
    repeat (n) begin
      if (six) inc6 = 1'b1; else inc4 = 1'b1;
      step(1);
      inc4 = 1'b0;
      inc6 = 1'b0;
      step(1);
    end
  endtask

  task automatic reset_all();
    rst = 1'b1;
    step(3);
    rst = 1'b0;
  endtask

  task automatic digit4(input int idx, output logic [3:0] v, output logic dp);
    logic [3:0] want;
    want = 4'b0001 << idx;
    for (int i = 0; i < 20 && en4 != want; i++) step(1);
    if (en4 != want) chk("scan_timeout", int'(en4), int'(want));
    v = bcd4;
    dp = dp4;
  endtask

  initial begin
    logic [3:0] a, b;
    logic da, db;
    int n, m;
    tv[0] = '{8'h00, 1'b1, 4'h1, 4'h2, 1'b0};
    tv[1] = '{8'h00, 1'b0, 4'h0, 4'h0, 1'b0};
    tv[2] = '{8'h01, 1'b1, 4'hF, 4'h1, 1'b0};
    tv[3] = '{8'h11, 1'b1, 4'h1, 4'h1, 1'b0};
    tv[4] = '{8'h12, 1'b1, 4'h1, 4'h2, 1'b1};
    tv[5] = '{8'h12, 1'b0, 4'h1, 4'h2, 1'b0};
    tv[6] = '{8'h13, 1'b1, 4'hF, 4'h1, 1'b1};
    tv[7] = '{8'h13, 1'b0, 4'h1, 4'h3, 1'b0};
    tv[8] = '{8'h23, 1'b1, 4'h1, 4'h1, 1'b1};
    tv[9] = '{8'h23, 1'b0, 4'h2, 4'h3, 1'b0};

    // reset state and first scan advance
    step(3);
    chk("rst_hh", hh4, 0);
    chk("rst_mm", mm4, 0);
    chk("rst_ss", ss4, 0);
    chk("rst_en", en4, 4'b0001);
    chk("rst_setting", set4, 0);
    chk("rst_bcd", bcd4, 0);
    chk("rst_dp", dp4, 0);
    chk("rst_pm", pm4, 0);
    rst = 1'b0;
    step(1);
    chk("scan_hold", en4, 4'b0001);
    step(1);
    chk("scan_adv", en4, 4'b0010);

    // 23:59:59 rollover, prescaler restarted on return to RUN
    step(1);
    pulse_mode(1);
    bump(1, 23);
    pulse_mode(1);
    bump(1, 59);
    pulse_mode(1);
    bump(1, 59);
    chk("set_hh", hh6, 8'h23);
    chk("set_mm", mm6, 8'h59);
    chk("set_ss", ss6, 8'h59);
    pulse_mode(1);
    chk("back_run", set6, 0);
    step(9);
    chk("pre_tick_ss", ss6, 8'h59);
    step(1);
    chk("roll_hh", hh6, 0);
    chk("roll_mm", mm6, 0);
    chk("roll_ss", ss6, 0);

    // 12/24 h formatting table
    reset_all();
    pulse_mode(0);
    for (int i = 0; i < 10; i++) begin
      for (int t = 0; t < 30 && hh4 != tv[i].hh; t++) bump(0, 1);
      chk("hh_reach", hh4, tv[i].hh);
      fmt = tv[i].fmt;
      step(3);
      digit4(0, a, da);
      digit4(1, b, db);
      chk($sformatf("tens[%0d]", i), a, tv[i].tens);
      chk($sformatf("ones[%0d]", i), b, tv[i].ones);
      chk($sformatf("pm[%0d]", i), pm4, tv[i].pm);
    end
    fmt = 1'b0;

    // hold-to-repeat on minutes
    reset_all();
    pulse_mode(0);
    pulse_mode(0);
    bump(0, 58);
    chk("mm_58", mm4, 8'h58);
    digit4(3, a, da);
    chk("dp_min_ones", da, 1);
    digit4(1, b, db);
    chk("dp_hour_ones", db, 0);
    inc4 = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      step(1);
      n = 1 + (k >= 21 ? 1 + (k - 21) / 5 : 0);
      m = (58 + n) % 60;
      chk($sformatf("rep_mm[%0d]", k), mm4, (m / 10) * 16 + m % 10);
    end
    inc4 = 1'b0;
    step(1);
    chk("rep_release", mm4, 8'h03);
    chk("rep_hh", hh4, 0);

    // mode sequencing and mode/inc collision
    reset_all();
    pulse_mode(0); chk("m4_1", set4, 1);
    pulse_mode(0); chk("m4_2", set4, 2);
    pulse_mode(0); chk("m4_3", set4, 0);
    pulse_mode(1); chk("m6_1", set6, 1);
    pulse_mode(1); chk("m6_2", set6, 2);
    pulse_mode(1); chk("m6_3", set6, 3);
    pulse_mode(1); chk("m6_4", set6, 0);
    pulse_mode(0);
    mode4 = 1'b1;
    inc4 = 1'b1;
    step(1);
    mode4 = 1'b0;
    inc4 = 1'b0;
    chk("coll_state", set4, 2);
    chk("coll_hh", hh4, 0);
    step(2);
    chk("coll_hh2", hh4, 0);
    chk("coll_mm", mm4, 0);

    // reset mid-set with i_inc held
    pulse_mode(0);
    pulse_mode(0);
    bump(0, 5);
    chk("pre_rst_hh", hh4, 8'h05);
    inc4 = 1'b1;
    step(1);
    chk("held_hh", hh4, 8'h06);
    rst = 1'b1;
    step(1);
    chk("mid_rst_set", set4, 0);
    chk("mid_rst_hh", hh4, 0);
    chk("mid_rst_mm", mm4, 0);
    chk("mid_rst_ss", ss4, 0);
    rst = 1'b0;
    step(5);
    chk("run_inc_hh", hh4, 0);
    chk("run_inc_mm", mm4, 0);
    pulse_mode(0);
    chk("enter_hh", hh4, 0);
    step(1);
    chk("enter_edge_hh", hh4, 8'h01);
    inc4 = 1'b0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
